// File: rtl/pipe_pkg.sv
// Shared pipeline types: writeback source encoding, load funct3 codes and the
// MEM/WB pipeline register layout.
package pipe_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // wb_sel is kept as raw bits so the reserved code 3 is representable.
  typedef struct packed {
    logic        valid;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_ren;
    logic [2:0]  funct3;
    logic [1:0]  wb_sel;
  } mem_wb_t;

endpackage

// File: rtl/load_align.sv
// Combinational load aligner: picks the byte/half/word at the given offset,
// extends it per funct3 and flags alignment faults.
module load_align
  import pipe_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{offset, 3'b000} +: 8];
  assign half_sel = offset[1] ? word[31:16] : word[15:0];

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    data       = word;
    misaligned = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU: data = {24'h0, byte_sel};
      F3_LH: begin
        data       = {{16{half_sel[15]}}, half_sel};
        misaligned = offset[0];
      end
      F3_LHU: begin
        data       = {16'h0, half_sel};
        misaligned = offset[0];
      end
      F3_LW:  misaligned = (offset != 2'b00);
      default: data = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback stage: aligns load data, selects the
// writeback source, drives the register-file port and counts retirements.
module wb_stage
  import pipe_pkg::*;
#(
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [31:0]          in_alu_result,
  input  logic [31:0]          in_pc_plus4,
  input  logic [4:0]           in_rd,
  input  logic                 in_reg_we,
  input  logic                 in_mem_ren,
  input  logic [2:0]           in_funct3,
  input  logic [1:0]           in_wb_sel,
  input  logic [31:0]          mem_rdata,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic                 load_misaligned,
  output logic [INSTRET_W-1:0] instret
);

  mem_wb_t              wb_q, wb_d;
  logic [31:0]          held_rdata_q, held_rdata_d;
  logic                 held_valid_q, held_valid_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;

  logic [31:0] sel_word;
  logic [31:0] load_data;
  logic        align_mis;
  logic        misaligned;
  logic        retire;

  // The memory word only lives for one cycle, so a stalled load reads the copy.
  assign sel_word = held_valid_q ? held_rdata_q : mem_rdata;

  load_align u_load_align (
    .word       (sel_word),
    .offset     (wb_q.alu_result[1:0]),
    .funct3     (wb_q.funct3),
    .data       (load_data),
    .misaligned (align_mis)
  );

  assign misaligned = wb_q.valid & wb_q.mem_ren & align_mis;
  assign retire     = wb_q.valid & ~stall & ~misaligned;

  always_comb begin
    wb_d         = wb_q;
    held_rdata_d = held_rdata_q;
    held_valid_d = held_valid_q;
    if (!stall) begin
      wb_d.valid      = in_valid & ~flush;
      wb_d.alu_result = in_alu_result;
      wb_d.pc_plus4   = in_pc_plus4;
      wb_d.rd         = in_rd;
      wb_d.reg_we     = in_reg_we;
      wb_d.mem_ren    = in_mem_ren;
      wb_d.funct3     = in_funct3;
      wb_d.wb_sel     = in_wb_sel;
      held_valid_d    = 1'b0;
    end else if (!held_valid_q) begin
      held_rdata_d = mem_rdata;
      held_valid_d = 1'b1;
    end
    instret_d = instret_q + {{(INSTRET_W-1){1'b0}}, retire};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q         <= '0;
      held_valid_q <= 1'b0;
      instret_q    <= '0;
    end else begin
      wb_q         <= wb_d;
      held_valid_q <= held_valid_d;
      instret_q    <= instret_d;
    end
  end

  // NOTE: held_rdata is pure data qualified by held_valid, so it has no reset.
  always_ff @(posedge clk) begin
    held_rdata_q <= held_rdata_d;
  end

  always_comb begin
    case (wb_q.wb_sel)
      WB_MEM:  rf_wdata = load_data;
      WB_PC4:  rf_wdata = wb_q.pc_plus4;
      default: rf_wdata = wb_q.alu_result;
    endcase
  end

  assign rf_waddr        = wb_q.rd;
  assign rf_we           = wb_q.valid & wb_q.reg_we & (wb_q.rd != 5'd0) & ~misaligned & ~stall;
  assign load_misaligned = misaligned;
  assign instret         = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expectations are queued at issue time and
// compared when the instruction occupies WB.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc_plus4;
  logic [4:0]  in_rd;
  logic        in_reg_we;
  logic        in_mem_ren;
  logic [2:0]  in_funct3;
  logic [1:0]  in_wb_sel;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        flush;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        load_misaligned;
  logic [63:0] instret;

  wb_stage #(.INSTRET_W(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_alu_result   (in_alu_result),
    .in_pc_plus4     (in_pc_plus4),
    .in_rd           (in_rd),
    .in_reg_we       (in_reg_we),
    .in_mem_ren      (in_mem_ren),
    .in_funct3       (in_funct3),
    .in_wb_sel       (in_wb_sel),
    .mem_rdata       (mem_rdata),
    .stall           (stall),
    .flush           (flush),
    .rf_we           (rf_we),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata),
    .load_misaligned (load_misaligned),
    .instret         (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        mis;
    logic        retire;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_instret = 64'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input string tag, input logic [2:0] f3, input logic ren,
                       input logic [1:0] sel, input logic [4:0] rd, input logic we,
                       input logic [31:0] alu, input logic [31:0] pc4,
                       input logic [31:0] rdata, input logic fl, input int n_stall,
                       input logic e_we, input logic [31:0] e_wdata,
                       input logic e_mis, input logic e_ret);
    exp_t e;
    e = '{we: e_we, waddr: rd, wdata: e_wdata, mis: e_mis, retire: e_ret};
    @(negedge clk);
    in_valid      = 1'b1;
    in_funct3     = f3;
    in_mem_ren    = ren;
    in_wb_sel     = sel;
    in_rd         = rd;
    in_reg_we     = we;
    in_alu_result = alu;
    in_pc_plus4   = pc4;
    flush         = fl;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    mem_rdata = rdata;
    stall     = (n_stall > 0);
    for (int i = 0; i < n_stall; i++) begin
      #1;
      check({tag, "_stall_we"}, {63'd0, rf_we}, 64'd0);
      check({tag, "_stall_wdata"}, {32'd0, rf_wdata}, {32'd0, e_wdata});
      check({tag, "_stall_cnt"}, instret, exp_instret);
      @(posedge clk);
      #1;
      mem_rdata = 32'h0;
      if (i == n_stall - 1) stall = 1'b0;
    end
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_we"}, {63'd0, rf_we}, {63'd0, e.we});
      check({tag, "_waddr"}, {59'd0, rf_waddr}, {59'd0, e.waddr});
      check({tag, "_wdata"}, {32'd0, rf_wdata}, {32'd0, e.wdata});
      check({tag, "_mis"}, {63'd0, load_misaligned}, {63'd0, e.mis});
      check({tag, "_cnt"}, instret, exp_instret);
      if (e.retire) exp_instret++;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_alu_result = '0; in_pc_plus4 = '0;
    in_rd = '0; in_reg_we = 1'b0; in_mem_ren = 1'b0; in_funct3 = '0;
    in_wb_sel = '0; mem_rdata = '0; stall = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", {63'd0, rf_we}, 64'd0);
    check("rst_waddr", {59'd0, rf_waddr}, 64'd0);
    check("rst_wdata", {32'd0, rf_wdata}, 64'd0);
    check("rst_mis", {63'd0, load_misaligned}, 64'd0);
    check("rst_cnt", instret, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    //     tag        f3      ren  sel   rd     we    alu           pc4    rdata          fl  st  e_we  e_wdata        mis  ret
    issue("lw",      3'b010, 1, 2'd1, 5'd5,  1, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 0, 1, 32'hDEAD_BEEF, 0, 1);
    issue("lb_103",  3'b000, 1, 2'd1, 5'd6,  1, 32'h0000_0103, 32'h0, 32'h8011_2233, 0, 0, 1, 32'hFFFF_FF80, 0, 1);
    issue("lbu_103", 3'b100, 1, 2'd1, 5'd6,  1, 32'h0000_0103, 32'h0, 32'h8011_2233, 0, 0, 1, 32'h0000_0080, 0, 1);
    issue("lb_100",  3'b000, 1, 2'd1, 5'd6,  1, 32'h0000_0100, 32'h0, 32'h8011_2233, 0, 0, 1, 32'h0000_0033, 0, 1);
    issue("lb_101",  3'b000, 1, 2'd1, 5'd6,  1, 32'h0000_0101, 32'h0, 32'h8011_2233, 0, 0, 1, 32'h0000_0022, 0, 1);
    issue("lh_102",  3'b001, 1, 2'd1, 5'd7,  1, 32'h0000_0102, 32'h0, 32'h8001_1234, 0, 0, 1, 32'hFFFF_8001, 0, 1);
    issue("lhu_100", 3'b101, 1, 2'd1, 5'd7,  1, 32'h0000_0100, 32'h0, 32'h8001_1234, 0, 0, 1, 32'h0000_1234, 0, 1);
    issue("lh_101",  3'b001, 1, 2'd1, 5'd7,  1, 32'h0000_0101, 32'h0, 32'h8001_1234, 0, 0, 0, 32'h0000_1234, 1, 0);
    issue("lw_102",  3'b010, 1, 2'd1, 5'd7,  1, 32'h0000_0102, 32'h0, 32'h8001_1234, 0, 0, 0, 32'h8001_1234, 1, 0);
    issue("lw_stall",3'b010, 1, 2'd1, 5'd8,  1, 32'h0000_0200, 32'h0, 32'h1122_3344, 0, 3, 1, 32'h1122_3344, 0, 1);
    issue("add_fl",  3'b000, 0, 2'd0, 5'd3,  1, 32'h0000_0055, 32'h0, 32'h0,         1, 0, 0, 32'h0000_0055, 0, 0);
    issue("add",     3'b000, 0, 2'd0, 5'd3,  1, 32'h1234_5678, 32'h0, 32'h0,         0, 0, 1, 32'h1234_5678, 0, 1);
    issue("add_x0",  3'b000, 0, 2'd0, 5'd0,  1, 32'h0000_0077, 32'h0, 32'h0,         0, 0, 0, 32'h0000_0077, 0, 1);
    issue("jal",     3'b000, 0, 2'd2, 5'd1,  1, 32'h0000_0300, 32'h204, 32'h0,       0, 0, 1, 32'h0000_0204, 0, 1);
    issue("sel_rsv", 3'b000, 0, 2'd3, 5'd4,  1, 32'h0000_ABCD, 32'h208, 32'h0,       0, 0, 1, 32'h0000_ABCD, 0, 1);
    issue("store",   3'b010, 0, 2'd0, 5'd9,  0, 32'h0000_0400, 32'h0, 32'h0,         0, 0, 0, 32'h0000_0400, 0, 1);

    // Reset while a captured load is stalled in WB.
    @(negedge clk);
    in_valid = 1'b1; in_funct3 = 3'b010; in_mem_ren = 1'b1; in_wb_sel = 2'd1;
    in_rd = 5'd9; in_reg_we = 1'b1; in_alu_result = 32'h0000_0300;
    @(posedge clk);
    #1;
    in_valid = 1'b0; mem_rdata = 32'hCAFE_F00D; stall = 1'b1;
    @(posedge clk);
    #1;
    mem_rdata = 32'h0;
    check("rstall_we", {63'd0, rf_we}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rstall_we0", {63'd0, rf_we}, 64'd0);
    check("rstall_waddr", {59'd0, rf_waddr}, 64'd0);
    check("rstall_wdata", {32'd0, rf_wdata}, 64'd0);
    check("rstall_mis", {63'd0, load_misaligned}, 64'd0);
    check("rstall_cnt", instret, 64'd0);
    check("rstall_held", {63'd0, dut.held_valid_q}, 64'd0);
    rst = 1'b0; stall = 1'b0;
    exp_instret = 64'd0;

    issue("lw_post",  3'b010, 1, 2'd1, 5'd10, 1, 32'h0000_0104, 32'h0, 32'h55AA_00FF, 0, 0, 1, 32'h55AA_00FF, 0, 1);
    issue("add_post", 3'b000, 0, 2'd0, 5'd11, 1, 32'h0000_0099, 32'h0, 32'h0,         0, 0, 1, 32'h0000_0099, 0, 1);
    @(posedge clk);
    #1;
    check("final_cnt", instret, exp_instret);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
